// File: rtl/img_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// img_frame_sequencer_if
// Pixel bus around the frame sequencer: the RGB source handshake on one side
// and the per_img_* stream toward the RGB2YCbCr datapath on the other.
//
// Handshake: a source pixel moves on a rising sys_clk edge exactly when
// src_valid and src_ready are both high in the cycle before that edge.
// src_valid may rise or fall at any time and is not required to hold.
// src_ready depends only on the sequencer state and abort, never on
// src_valid, so there is no combinational loop.
//
// Modports
//   master : pixel source / downstream observer (drives src_*, reads the rest)
//   slave  : the sequencer (reads src_*, drives src_ready and per_img_*)
// ---------------------------------------------------------------------------
interface img_frame_sequencer_if;
   logic       src_valid;
   logic       src_ready;
   logic [7:0] src_red;
   logic [7:0] src_green;
   logic [7:0] src_blue;
   logic       per_img_vsync;
   logic       per_img_href;
   logic [7:0] per_img_red;
   logic [7:0] per_img_green;
   logic [7:0] per_img_blue;

   modport master (
      output src_valid, src_red, src_green, src_blue,
      input  src_ready,
      input  per_img_vsync, per_img_href, per_img_red, per_img_green, per_img_blue
   );

   modport slave (
      input  src_valid, src_red, src_green, src_blue,
      output src_ready,
      output per_img_vsync, per_img_href, per_img_red, per_img_green, per_img_blue
   );
endinterface

// File: rtl/img_frame_sequencer.sv
// ---------------------------------------------------------------------------
// img_frame_sequencer
// Frame-timing controller in front of the RGB2YCbCr datapath. On start it
// frames one IMG_WIDTH x IMG_HEIGHT picture: vsync rises, V_LEAD lead cycles,
// then lines of IMG_WIDTH accepted pixels separated by H_BLANK blanking
// cycles, then V_TAIL tail cycles before vsync falls. With continuous set at
// frame end it waits H_BLANK cycles with vsync low and starts again.
//
// Ports
//   sys_clk, sys_rst   clock, asynchronous active-low reset
//   start              1-cycle frame request, ignored while busy
//   abort              synchronous cancel, wins over everything else
//   continuous         sampled at frame end: restart after a vsync-low gap
//   bus (slave)        source handshake in, per_img_* stream out
//   busy               sequencer is not idle
//   frame_done         1-cycle pulse with the vsync fall of a finished frame
//   stall_cnt          saturating count of LINE cycles with no source pixel
//   state_dbg          current FSM state encoding
// ---------------------------------------------------------------------------
module img_frame_sequencer #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int V_LEAD     = 5,
   parameter int H_BLANK    = 10,
   parameter int V_TAIL     = 5
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        continuous,
   img_frame_sequencer_if.slave        bus,
   output logic                        busy,
   output logic                        frame_done,
   output logic [15:0]                 stall_cnt,
   output logic [2:0]                  state_dbg
);

   localparam int MAX_LH = (V_LEAD > H_BLANK) ? V_LEAD : H_BLANK;
   localparam int MAX_T  = (MAX_LH > V_TAIL) ? MAX_LH : V_TAIL;
   localparam int TW     = $clog2(MAX_T + 1);
   localparam int CW     = $clog2(IMG_WIDTH + 1);
   localparam int RW     = $clog2(IMG_HEIGHT + 1);

   localparam logic [TW-1:0] LEAD_LAST  = TW'(V_LEAD - 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'(H_BLANK - 1);
   localparam logic [TW-1:0] TAIL_LAST  = TW'(V_TAIL - 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
   localparam logic [15:0]   STALL_MAX  = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_VS_LEAD = 3'd1,
      S_LINE    = 3'd2,
      S_HBLANK  = 3'd3,
      S_VS_TAIL = 3'd4,
      S_VS_GAP  = 3'd5
   } state_t;

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;
   logic          src_ready;
   logic          accept;
   logic          line_end;
   logic          last_row;
   logic          tail_done;
   logic          vsync_n;
   logic          vsync_q;
   logic          href_q;
   logic [7:0]    red_q, green_q, blue_q;
   logic          done_q;
   logic [15:0]   stall_q;

   assign src_ready = (state == S_LINE) & ~abort;
   assign accept    = bus.src_valid & src_ready;
   assign line_end  = accept & (col_cnt == COL_LAST);
   assign last_row  = (row_cnt == ROW_LAST);
   assign tail_done = (state == S_VS_TAIL) & (timer == TAIL_LAST);

   always_comb begin
      state_n = state;
      timer_n = '0;
      vsync_n = 1'b0;
      case (state)
         S_IDLE:    if (start) state_n = S_VS_LEAD;
         S_VS_LEAD: if (timer == LEAD_LAST) state_n = S_LINE;
         S_LINE:    if (line_end) state_n = last_row ? S_VS_TAIL : S_HBLANK;
         S_HBLANK:  if (timer == BLANK_LAST) state_n = S_LINE;
         S_VS_TAIL: if (tail_done) state_n = continuous ? S_VS_GAP : S_IDLE;
         S_VS_GAP:  if (timer == BLANK_LAST) state_n = S_VS_LEAD;
         default:   state_n = S_IDLE;
      endcase
      if (abort) state_n = S_IDLE;

      // One shared timer: restarts at 0 on every state change, counts
      // only inside the timed states.
      if ((state_n == state) && (state != S_IDLE) && (state != S_LINE))
         timer_n = timer + TW'(1);

      // vsync is registered from the next state so it rises the cycle
      // after start is taken and drops together with the move to IDLE/VS_GAP.
      vsync_n = (state_n == S_VS_LEAD) || (state_n == S_LINE) ||
                (state_n == S_HBLANK)  || (state_n == S_VS_TAIL);
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state   <= S_IDLE;
         timer   <= '0;
         col_cnt <= '0;
         row_cnt <= '0;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         done_q  <= 1'b0;
         stall_q <= '0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         vsync_q <= vsync_n;
         href_q  <= accept;
         done_q  <= tail_done & ~abort;

         if (abort) begin
            col_cnt <= '0;
            row_cnt <= '0;
         end else if (accept) begin
            col_cnt <= line_end ? '0 : col_cnt + CW'(1);
            if (line_end) row_cnt <= last_row ? '0 : row_cnt + RW'(1);
         end

         if (accept) begin
            red_q   <= bus.src_red;
            green_q <= bus.src_green;
            blue_q  <= bus.src_blue;
         end

         // Continuous frames keep accumulating; only an accepted start clears.
         if ((state == S_IDLE) && start && !abort)
            stall_q <= '0;
         else if ((state == S_LINE) && !bus.src_valid && (stall_q != STALL_MAX))
            stall_q <= stall_q + 16'd1;
      end
   end

   assign bus.src_ready     = src_ready;
   assign bus.per_img_vsync = vsync_q;
   assign bus.per_img_href  = href_q;
   assign bus.per_img_red   = red_q;
   assign bus.per_img_green = green_q;
   assign bus.per_img_blue  = blue_q;
   assign busy              = (state != S_IDLE);
   assign frame_done        = done_q;
   assign stall_cnt         = stall_q;
   assign state_dbg         = state;

endmodule

// File: tb/tb_img_frame_sequencer.sv
module tb_img_frame_sequencer;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int VL = 5;
   localparam int HB = 10;
   localparam int VT = 2;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        continuous = 1'b0;
   logic        busy;
   logic        frame_done;
   logic [15:0] stall_cnt;
   logic [2:0]  state_dbg;

   img_frame_sequencer_if bus ();

   img_frame_sequencer #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .V_LEAD(VL), .H_BLANK(HB), .V_TAIL(VT)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
      .continuous(continuous), .bus(bus), .busy(busy), .frame_done(frame_done),
      .stall_cnt(stall_cnt), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 sys_clk = ~sys_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- check bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- stimulus controls (written by the test only) ----------------
   int base      = 0;   // pixel index that maps to value 0 for this run
   int stall_at  = -1;  // relative pixel index at which the source stalls
   int stall_len = 0;   // number of cycles src_valid is held low there

   // ---------------- source driver ----------------
   int pix_idx    = 0;
   int cyc_at_idx = 0;
   bit pending_acc = 1'b0;   // written by the monitor only

   always @(posedge sys_clk) begin
      int rel;
      #1;
      if (pending_acc) begin
         pix_idx++;
         cyc_at_idx = 0;
      end else begin
         cyc_at_idx++;
      end
      rel = pix_idx - base;
      bus.src_valid = !((stall_len > 0) && (rel == stall_at) && (cyc_at_idx < stall_len));
      bus.src_red   = 8'(rel);
      bus.src_green = 8'(rel);
      bus.src_blue  = 8'(rel);
   end

   // ---------------- compare process / scoreboard ----------------
   logic [23:0] exp_q[$];
   int vs_runs[$];
   int gap_runs[$];
   int href_runs[$];
   int fd_total  = 0;
   int emit_cnt  = 0;
   int acc_cnt   = 0;
   int last_pix  = -1;
   bit prev_acc  = 1'b0;
   bit prev_vs   = 1'b0;
   bit prev_busy = 1'b0;
   int vs_run = 0, low_run = 0, href_run = 0;

   always @(negedge sys_clk) begin
      bit acc;
      logic [23:0] want;
      if (!sys_rst) begin
         pending_acc = 1'b0;
         prev_acc = 1'b0;
         prev_vs = 1'b0;
         prev_busy = 1'b0;
         exp_q.delete();
         vs_run = 0;
         low_run = 0;
         href_run = 0;
      end else begin
         // Output stream: one pixel per accept, one cycle later, in order.
         check("href_latency", bus.per_img_href, prev_acc);
         if (prev_acc && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("pixel_data", {bus.per_img_red, bus.per_img_green, bus.per_img_blue}, want);
         end
         if (bus.src_ready) check("ready_in_vsync", bus.per_img_vsync, 1);
         if (bus.per_img_href) check("href_in_vsync", bus.per_img_vsync, 1);
         if (frame_done) check("done_on_vsync_fall", {prev_vs, bus.per_img_vsync}, 2'b10);

         if (bus.per_img_vsync) vs_run++;
         else if (prev_vs) begin
            vs_runs.push_back(vs_run);
            vs_run = 0;
         end
         if (!bus.per_img_vsync) low_run++;
         else begin
            if (!prev_vs && prev_busy && low_run > 0) gap_runs.push_back(low_run);
            low_run = 0;
         end
         if (bus.per_img_href) href_run++;
         else if (href_run > 0) begin
            href_runs.push_back(href_run);
            href_run = 0;
         end

         if (frame_done) fd_total++;
         if (bus.per_img_href) begin
            emit_cnt++;
            last_pix = int'(bus.per_img_red);
         end

         acc = bus.src_valid & bus.src_ready;
         if (acc) begin
            exp_q.push_back({bus.src_red, bus.src_green, bus.src_blue});
            acc_cnt++;
         end
         pending_acc = acc;
         prev_acc = acc;
         prev_vs = bus.per_img_vsync;
         prev_busy = busy;
      end
   end

   // ---------------- behavioural frame model ----------------
   // Vsync envelope: lead, every line's pixel and stall cycles, the blanking
   // between lines and the tail.
   function automatic int exp_vs_len(input int stalls);
      return VL + W * H + stalls + (H - 1) * HB + VT;
   endfunction

   // Href runs: a run ends at every line boundary and where the source stalls.
   int exp_runs[$];
   task automatic build_runs(input int s_at, input int s_len);
      int run;
      run = 0;
      exp_runs.delete();
      for (int p = 0; p < W * H; p++) begin
         run++;
         if ((p % W == W - 1) || (s_len > 0 && p + 1 == s_at)) begin
            exp_runs.push_back(run);
            run = 0;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      @(posedge sys_clk); #2 start = 1'b1;
      @(posedge sys_clk); #2 start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge sys_clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, ok, 1);
      repeat (2) @(posedge sys_clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_vsync"}, bus.per_img_vsync, 0);
      check({tag, "_href"}, bus.per_img_href, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_ready"}, bus.src_ready, 0);
      check({tag, "_done"}, frame_done, 0);
   endtask

   // One complete frame with optional source stall; lit_vs pins the model.
   task automatic run_frame(input string tag, input int s_at, input int s_len, input int lit_vs);
      int vs_rd, hr_rd, fd0, em0;
      @(posedge sys_clk); #2;
      base = pix_idx;
      stall_at = s_at;
      stall_len = s_len;
      vs_rd = vs_runs.size();
      hr_rd = href_runs.size();
      fd0 = fd_total;
      em0 = emit_cnt;
      build_runs(s_at, s_len);
      pulse_start();
      check({tag, "_busy_after_start"}, busy, 1);
      wait_idle({tag, "_finish"}, 400);
      check({tag, "_vs_len_model"}, (vs_runs.size() > vs_rd) ? vs_runs[vs_rd] : -1, exp_vs_len(s_len));
      check({tag, "_vs_len_literal"}, (vs_runs.size() > vs_rd) ? vs_runs[vs_rd] : -1, lit_vs);
      check({tag, "_href_run_count"}, href_runs.size() - hr_rd, exp_runs.size());
      for (int i = 0; i < exp_runs.size(); i++)
         check({tag, "_href_run"}, (href_runs.size() > hr_rd + i) ? href_runs[hr_rd + i] : -1, exp_runs[i]);
      check({tag, "_frame_done"}, fd_total - fd0, 1);
      check({tag, "_pixels_out"}, emit_cnt - em0, W * H);
      check({tag, "_last_pixel"}, last_pix, 11);
      check({tag, "_stall_cnt"}, stall_cnt, s_len);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      stall_len = 0;
      stall_at = -1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int vs_rd, gp_rd, fd0, em0, ac0;
      bit ok;

      // Reset state
      repeat (3) @(negedge sys_clk);
      check_idle_outputs("reset");
      check("reset_stall_cnt", stall_cnt, 0);
      check("reset_red", bus.per_img_red, 0);
      @(posedge sys_clk); #2 sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      check_idle_outputs("post_reset");

      // Plain frame: 39 vsync cycles, three runs of four
      run_frame("frame", -1, 0, 39);

      // Source stall of three cycles in the middle of line 2
      run_frame("stall", 6, 3, 42);

      // start and abort together while idle: stay idle
      @(posedge sys_clk); #2 start = 1'b1; abort = 1'b1;
      @(posedge sys_clk); #2 start = 1'b0; abort = 1'b0;
      @(negedge sys_clk);
      check("start_abort_busy", busy, 0);
      check("start_abort_vsync", bus.per_img_vsync, 0);

      // Abort on the 6th accept
      @(posedge sys_clk); #2;
      base = pix_idx;
      vs_rd = vs_runs.size();
      fd0 = fd_total;
      em0 = emit_cnt;
      ac0 = acc_cnt;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge sys_clk); #2;
         if (acc_cnt - ac0 == 5 && bus.src_ready && bus.src_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("abort_reach_6th", ok, 1);
      abort = 1'b1;
      @(posedge sys_clk); #2 abort = 1'b0;
      @(negedge sys_clk);
      check_idle_outputs("abort");
      repeat (3) @(posedge sys_clk);
      check("abort_vs_len", (vs_runs.size() > vs_rd) ? vs_runs[vs_rd] : -1, VL + W + HB + 2);
      check("abort_no_done", fd_total - fd0, 0);
      check("abort_pixels_out", emit_cnt - em0, 5);
      check("abort_accepts", acc_cnt - ac0, 5);
      check("abort_last_pixel", last_pix, 4);

      // A clean frame after abort
      run_frame("after_abort", -1, 0, 39);

      // Continuous mode with a start ignored mid-frame
      @(posedge sys_clk); #2;
      base = pix_idx;
      vs_rd = vs_runs.size();
      gp_rd = gap_runs.size();
      fd0 = fd_total;
      em0 = emit_cnt;
      continuous = 1'b1;
      pulse_start();
      repeat (20) @(posedge sys_clk);
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if (fd_total - fd0 >= 1) begin
            ok = 1'b1;
            break;
         end
      end
      check("cont_first_done", ok, 1);
      @(posedge sys_clk); #2 continuous = 1'b0;
      check("cont_busy_in_gap", busy, 1);
      wait_idle("cont_finish", 400);
      check("cont_done_count", fd_total - fd0, 2);
      check("cont_vs1", (vs_runs.size() > vs_rd) ? vs_runs[vs_rd] : -1, exp_vs_len(0));
      check("cont_vs2", (vs_runs.size() > vs_rd + 1) ? vs_runs[vs_rd + 1] : -1, 39);
      check("cont_gap", (gap_runs.size() > gp_rd) ? gap_runs[gp_rd] : -1, HB);
      check("cont_pixels_out", emit_cnt - em0, 2 * W * H);
      check("cont_last_pixel", last_pix, 23);
      check("cont_stall_cnt", stall_cnt, 0);

      // Asynchronous reset during line blanking
      @(posedge sys_clk); #2;
      base = pix_idx;
      fd0 = fd_total;
      em0 = emit_cnt;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (emit_cnt - em0 == W) begin
            ok = 1'b1;
            break;
         end
      end
      check("rst_reach_hblank", ok, 1);
      repeat (2) @(posedge sys_clk);
      #3 sys_rst = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      check("async_rst_stall", stall_cnt, 0);
      check("async_rst_red", bus.per_img_red, 0);
      repeat (2) @(posedge sys_clk);
      #2 sys_rst = 1'b1;
      repeat (6) @(negedge sys_clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_vsync", bus.per_img_vsync, 0);
      check("post_rst_no_done", fd_total - fd0, 0);

      // Sequencer still runs a normal frame afterwards
      run_frame("after_reset", -1, 0, 39);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
